// File: rtl/isram_resp.sv
// Instruction-fetch read responder. It accepts one address at a time and returns the
// stored word LATENCY cycles later from a word-addressed array that has a preload port.
`timescale 1ns/1ps
module isram_resp #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h80000000,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  sram_rst,
    input  logic                  ar_valid,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    output logic                  ar_ready,
    output logic                  r_valid,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_err,
    input  logic                  r_ready,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready. ar_addr is
    // taken only on such an edge. Once r_valid is raised, it stays high with r_data and
    // r_err unchanged until the edge where r_ready is also high.

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] rd_off;
    logic [ADDR_WIDTH-1:0] wr_off;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  rd_err;
    logic                  wr_err;

    // BASE_ADDR is word aligned, so the low offset bits equal the low address bits.
    // An address below the base wraps to a huge offset and fails the range test.
    assign rd_addr = (state == S_IDLE) ? ar_addr : addr_q;
    assign rd_off  = rd_addr - BASE_ADDR;
    assign rd_idx  = rd_off[DEPTH_LOG2+1:2];
    assign rd_err  = (rd_off[1:0] != 2'b00) || (rd_off[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0);

    assign wr_off  = w_addr - BASE_ADDR;
    assign wr_idx  = wr_off[DEPTH_LOG2+1:2];
    assign wr_err  = (wr_off[1:0] != 2'b00) || (wr_off[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0);

    assign ar_ready  = (state == S_IDLE);
    assign r_valid   = (state == S_RESP);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (w_en && !wr_err) begin
            mem[wr_idx] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge sram_rst) begin
        if (!sram_rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ar_valid) begin
                        addr_q <= ar_addr;
                        if (LATENCY == 1) begin
                            state  <= S_RESP;
                            r_data <= rd_err ? '0 : mem[rd_idx];
                            r_err  <= rd_err;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    // The array read sees its pre-edge contents, so a same-edge write is not returned.
                    if (cnt == 4'd1) begin
                        state  <= S_RESP;
                        r_data <= rd_err ? '0 : mem[rd_idx];
                        r_err  <= rd_err;
                    end
                end
                S_RESP: begin
                    if (r_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
